// File: rtl/reg_bank_arb.sv
//==============================================================================
// Module  : reg_bank_arb
// Purpose : Two-requester write arbiter for a four-entry 8-bit register bank.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module reg_bank_arb #(
    parameter int FIXED_PRIO = 0
) (
    input  logic       clock,
    input  logic       reset_N,
    input  logic       req_a,
    input  logic [1:0] addr_a,
    input  logic [7:0] data_a,
    output logic       ack_a,
    input  logic       req_b,
    input  logic [1:0] addr_b,
    input  logic [7:0] data_b,
    output logic       ack_b,
    output logic [3:0] wr_en,
    output logic [7:0] wr_data,
    output logic       busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] ACK   = 2'd2;

    localparam logic FIXED = (FIXED_PRIO != 0);

    logic [1:0] state;
    logic       sel_a;
    logic       last_a;

    logic       grant_a;
    logic [1:0] addr_sel;
    logic [7:0] data_sel;
    logic [3:0] addr_dec;

    // A wins when alone, or on a tie when prioritised or when B was served last.
    always_comb begin
        grant_a  = req_a && (!req_b || FIXED || !last_a);
        addr_sel = grant_a ? addr_a : addr_b;
        data_sel = grant_a ? data_a : data_b;
        addr_dec = 4'b0001 << addr_sel;
    end

    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            state   <= IDLE;
            sel_a   <= 1'b0;
            last_a  <= 1'b0;
            wr_en   <= 4'b0000;
            wr_data <= 8'h00;
            ack_a   <= 1'b0;
            ack_b   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ack_a <= 1'b0;
                    ack_b <= 1'b0;
                    if (req_a || req_b) begin
                        state   <= WRITE;
                        busy    <= 1'b1;
                        sel_a   <= grant_a;
                        last_a  <= grant_a;
                        wr_en   <= addr_dec;
                        wr_data <= data_sel;
                    end
                end
                WRITE: begin
                    state <= ACK;
                    wr_en <= 4'b0000;
                    ack_a <= sel_a;
                    ack_b <= !sel_a;
                end
                ACK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ack_a <= 1'b0;
                    ack_b <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    wr_en <= 4'b0000;
                    ack_a <= 1'b0;
                    ack_b <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
